qq_deq_fsm: RTL and testbench
=============================

# qq_deq_fsm

Dequeue controller for the QuickQ priority queue, the read side of the enqueue control FSM. On a dequeue request it reads the head entry (smallest key, address 0) from the queue BRAM and returns it. It then shifts every remaining entry one address toward the head, scrubs the vacated tail slot to all-ones and pulses a count decrement. It shares the BRAM port with the enqueue FSM through an external mux and never runs while `enq_busy` is high.

## Interface
Parameters:
- KEY_W, 32, key/entry width; the empty-slot marker is all-ones of KEY_W.
- DEPTH, 16, number of queue entries in BRAM.
- ADDR_W, $clog2(DEPTH), BRAM address width.
- CNT_W, $clog2(DEPTH+1), occupancy count width.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- deq  in  1  dequeue request; sampled only in IDLE.
- enq_busy  in  1  enqueue FSM active; blocks acceptance of `deq`.
- count  in  CNT_W  current occupancy, owned by the count register.
- deq_ready  out  1  high only in IDLE.
- deq_valid  out  1  one-cycle pulse; `deq_data` is valid in this cycle.
- deq_data  out  KEY_W  dequeued head key; registered and held until the next dequeue.
- deq_err  out  1  one-cycle pulse on a dequeue request while `count`==0.
- count_dec  out  1  one-cycle pulse; the count owner decrements by 1.
- bram_addr  out  ADDR_W  BRAM address.
- bram_we  out  1  BRAM write enable.
- bram_wdata  out  KEY_W  BRAM write data.
- bram_rdata  in  KEY_W  BRAM read data; valid one cycle after the address is presented (synchronous read).

## Operation
- The FSM states are IDLE, READ_HEAD, DEQ_RD, DEQ_SWAP, FILL_DEQ and CNT_DEC. The encoding is one-hot or binary; the choice is free.
- IDLE:
  - `deq_ready`=1 and `bram_addr`=0.
  - If `deq`=1, `enq_busy`=0 and `count`!=0: latch `count` into `cnt_r`, set `idx`=1 and go to READ_HEAD.
  - If `deq`=1, `enq_busy`=0 and `count`==0: pulse `deq_err` and stay in IDLE.
  - If `enq_busy`=1: ignore `deq`.
- READ_HEAD: register `bram_rdata` into `deq_data`. If `cnt_r`==1, go to FILL_DEQ; otherwise go to DEQ_RD.
- DEQ_RD: `bram_addr`=`idx`, `bram_we`=0. Go to DEQ_SWAP.
- DEQ_SWAP:
  - `bram_addr`=`idx`-1, `bram_wdata`=`bram_rdata`, `bram_we`=1.
  - Increment `idx`.
  - If `idx`+1==`cnt_r` before the increment, go to FILL_DEQ; otherwise go to DEQ_RD.
- FILL_DEQ: `bram_addr`=`cnt_r`-1, `bram_wdata`=all-ones, `bram_we`=1. Go to CNT_DEC.
- CNT_DEC: `count_dec`=1. Go to IDLE.
- Arithmetic: `idx` is ADDR_W+1 bits so the comparison never wraps. `cnt_r`-1 is evaluated only when `cnt_r`≥1.
- `count` changes while busy are ignored; `cnt_r` is the snapshot taken at acceptance.
- `bram_we` is 0 in every state except DEQ_SWAP and FILL_DEQ.

## Timing
- Reset values:
  - State is IDLE.
  - `deq_ready`=1.
  - `deq_valid`, `deq_err`, `count_dec` and `bram_we` are 0.
  - `deq_data`=0, `bram_addr`=0, `bram_wdata`=0.
- Cycle numbering: cycle 0 is the accepting cycle (IDLE with `deq`=1).
  - READ_HEAD is in cycle 1.
  - `deq_valid` pulses in cycle 2.
  - Each shifted entry costs 2 cycles (DEQ_RD then DEQ_SWAP).
  - `count_dec` pulses in cycle 2*`cnt_r`+1.
  - `deq_ready` rises in cycle 2*`cnt_r`+2.
- Full queue (`count`==DEPTH): 15 shifts; slot DEPTH-1 is scrubbed; `deq_ready` returns in cycle 34.
- Reset mid-operation: the FSM enters IDLE on the next edge and all outputs take their reset values. `count_dec` does not pulse. BRAM contents are then unspecified, and the queue owner must reinitialise them.
- Simultaneous `deq` and `enq_busy` rising: enqueue wins and the dequeue is not accepted. The requester holds `deq` until `deq_ready` and `enq_busy`=0.

## Configuration
- QQ_DEQ_SCRUB_EN defined: FILL_DEQ is present and the tail slot is written to all-ones. Latencies are as stated in Timing.
- QQ_DEQ_SCRUB_EN undefined:
  - FILL_DEQ is removed; DEQ_SWAP and READ_HEAD go directly to CNT_DEC.
  - The stale tail entry remains in BRAM, and `count` alone defines validity.
  - `count_dec` pulses in cycle 2*`cnt_r` and `deq_ready` rises in cycle 2*`cnt_r`+1.

## Test plan
- BRAM [3,7,9,12,FF..], `count`=4, `deq` pulse → `deq_data`=3 with `deq_valid` in cycle 2. BRAM becomes [7,9,12,FFFFFFFF]. `count_dec` pulses once in cycle 9 and `deq_ready` rises in cycle 10.
- `count`=0, `deq`=1 → `deq_err` pulses in cycle 0. `bram_we` is never asserted and the FSM stays in IDLE.
- `count`=1, BRAM[0]=5 → `deq_data`=5. Address 0 is written FFFFFFFF in cycle 2, `count_dec` pulses in cycle 3 and `deq_ready` rises in cycle 4.
- `count`=16 holding 0..15 → `deq_data`=0 and BRAM becomes 1..15,FFFFFFFF. `deq_ready` rises in cycle 34 (33 without QQ_DEQ_SCRUB_EN, with slot 15 still holding 15).
- `enq_busy`=1 with `deq` held for 5 cycles → no acceptance. Acceptance occurs in the first cycle after `enq_busy` falls.
- `rst` asserted in DEQ_SWAP with `count`=4 → IDLE next cycle with `bram_we`=0. `count_dec` never pulses and `deq_ready`=1.

Source files
------------

// File: rtl/qq_deq_fsm.sv
// QuickQ dequeue controller: pops the head key, shifts the queue toward address 0,
// optionally scrubs the vacated tail (QQ_DEQ_SCRUB_EN) and pulses a count decrement.
module qq_deq_fsm #(
  parameter int KEY_W  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deq,
  input  logic              enq_busy,
  input  logic [CNT_W-1:0]  count,
  output logic              deq_ready,
  output logic              deq_valid,
  output logic [KEY_W-1:0]  deq_data,
  output logic              deq_err,
  output logic              count_dec,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [KEY_W-1:0]  bram_wdata,
  input  logic [KEY_W-1:0]  bram_rdata
);

  // one extra bit so idx+1 never wraps against a full-queue cnt_r
  localparam int IW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_HEAD,
    DEQ_RD,
    DEQ_SWAP,
`ifdef QQ_DEQ_SCRUB_EN
    FILL_DEQ,
`endif
    CNT_DEC
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [IW-1:0]    idx, idx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_r     <= '0;
      idx       <= '0;
      deq_data  <= '0;
      deq_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt_r     <= cnt_n;
      idx       <= idx_n;
      deq_valid <= (state == READ_HEAD);
      if (state == READ_HEAD) deq_data <= bram_rdata;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt_r;
    idx_n      = idx;
    deq_ready  = 1'b0;
    deq_err    = 1'b0;
    count_dec  = 1'b0;
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = '0;
    case (state)
      IDLE: begin
        deq_ready = 1'b1;
        if (deq && !enq_busy) begin
          if (count != '0) begin
            cnt_n   = count;
            idx_n   = IW'(1);
            state_n = READ_HEAD;
          end else begin
            deq_err = 1'b1;
          end
        end
      end
      READ_HEAD: begin
        if (cnt_r == CNT_W'(1))
`ifdef QQ_DEQ_SCRUB_EN
          state_n = FILL_DEQ;
`else
          state_n = CNT_DEC;
`endif
        else
          state_n = DEQ_RD;
      end
      DEQ_RD: begin
        bram_addr = idx[ADDR_W-1:0];
        state_n   = DEQ_SWAP;
      end
      DEQ_SWAP: begin
        // read data of slot idx lands now; write it one slot toward the head
        bram_addr  = ADDR_W'(idx - IW'(1));
        bram_wdata = bram_rdata;
        bram_we    = 1'b1;
        idx_n      = idx + IW'(1);
        if (CNT_W'(idx_n) == cnt_r)
`ifdef QQ_DEQ_SCRUB_EN
          state_n = FILL_DEQ;
`else
          state_n = CNT_DEC;
`endif
        else
          state_n = DEQ_RD;
      end
`ifdef QQ_DEQ_SCRUB_EN
      FILL_DEQ: begin
        bram_addr  = ADDR_W'(cnt_r - CNT_W'(1));
        bram_wdata = '1;
        bram_we    = 1'b1;
        state_n    = CNT_DEC;
      end
`endif
      CNT_DEC: begin
        count_dec = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qq_deq_fsm.sv
// Bench for qq_deq_fsm: behavioural BRAM, head-key scoreboard and cycle-accurate
// latency checks for both scrub and non-scrub builds.
module tb_qq_deq_fsm;
  localparam int KEY_W = 32, DEPTH = 16, ADDR_W = 4, CNT_W = 5;
  localparam logic [KEY_W-1:0] ONES = '1;

  logic              clk = 1'b0;
  logic              rst, deq, enq_busy;
  logic [CNT_W-1:0]  count;
  logic              deq_ready, deq_valid, deq_err, count_dec, bram_we;
  logic [KEY_W-1:0]  deq_data, bram_wdata, bram_rdata;
  logic [ADDR_W-1:0] bram_addr;

  logic [KEY_W-1:0] mem [DEPTH];
  logic [KEY_W-1:0] img [DEPTH];
  logic             ld = 1'b0;
  logic [KEY_W-1:0] sb[$];
  int total = 0, passed = 0;

  qq_deq_fsm #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .deq(deq), .enq_busy(enq_busy), .count(count),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
    .deq_err(deq_err), .count_dec(count_dec), .bram_addr(bram_addr),
    .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  // synchronous-read BRAM model with a whole-image preload
  always @(posedge clk) begin
    if (ld) mem <= img;
    else if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  // scoreboard: every deq_valid must match the oldest expected head key
  always @(negedge clk) begin
    if (!rst && deq_valid) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL sb_unexpected: deq_valid with data %h, none expected", deq_data);
      else begin
        logic [KEY_W-1:0] e;
        e = sb.pop_front();
        if (deq_data !== e) $display("FAIL sb_data: got %h expected %h", deq_data, e);
        else passed++;
      end
    end
  end

  function automatic int exp_dc(input int n);
`ifdef QQ_DEQ_SCRUB_EN
    return 2*n + 1;
`else
    return 2*n;
`endif
  endfunction
  function automatic int exp_rc(input int n);
    return exp_dc(n) + 1;
  endfunction
  function automatic int exp_wn(input int n);
`ifdef QQ_DEQ_SCRUB_EN
    return n;
`else
    return n - 1;
`endif
  endfunction
  function automatic logic [KEY_W-1:0] exp_tail(input logic [KEY_W-1:0] stale);
`ifdef QQ_DEQ_SCRUB_EN
    return ONES;
`else
    return stale;
`endif
  endfunction

  // all tasks start and end just after a rising edge
  task automatic load();
    ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
  endtask

  // issue one request and record event cycles relative to cycle 0 (acceptance)
  task automatic run_deq(input int cnt, output int vc, output int dc, output int dn,
                         output int rc, output int ec, output int wn);
    count = CNT_W'(cnt); deq = 1'b1;
    vc = -1; dc = -1; dn = 0; rc = -1; ec = 0; wn = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (deq_valid) vc = k;
      if (count_dec) begin dn++; if (dc < 0) dc = k; end
      if (deq_err) ec++;
      if (bram_we) wn++;
      if (k > 0 && deq_ready) begin rc = k; break; end
      @(posedge clk); #1 deq = 1'b0;
    end
    deq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({deq_ready, deq_valid, deq_err, count_dec, bram_we} !== 5'b10000 ||
        deq_data !== '0 || bram_addr !== '0 || bram_wdata !== '0)
      $display("FAIL reset: rdy=%b vld=%b err=%b dec=%b we=%b data=%h addr=%h wd=%h required 1 0 0 0 0 0 0 0",
               deq_ready, deq_valid, deq_err, count_dec, bram_we, deq_data, bram_addr, bram_wdata);
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int vc, dc, dn, rc, ec, wn;
    logic [KEY_W-1:0] e [4];
    foreach (img[i]) img[i] = ONES;
    img[0] = 3; img[1] = 7; img[2] = 9; img[3] = 12;
    load();
    sb.push_back(32'd3);
    run_deq(4, vc, dc, dn, rc, ec, wn);
    total++; if (vc !== 2) $display("FAIL basic_valid_cycle: got %0d required 2", vc); else passed++;
    total++; if (dc !== exp_dc(4) || dn !== 1) $display("FAIL basic_dec: cycle %0d n %0d required cycle %0d n 1", dc, dn, exp_dc(4)); else passed++;
    total++; if (rc !== exp_rc(4)) $display("FAIL basic_ready: got %0d required %0d", rc, exp_rc(4)); else passed++;
    total++; if (wn !== exp_wn(4)) $display("FAIL basic_writes: got %0d required %0d", wn, exp_wn(4)); else passed++;
    e[0] = 7; e[1] = 9; e[2] = 12; e[3] = exp_tail(32'd12);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[i] !== e[i]) $display("FAIL basic_mem%0d: got %h required %h", i, mem[i], e[i]);
      else passed++;
    end
    total++; if (deq_data !== 32'd3) $display("FAIL basic_hold: got %h required 3", deq_data); else passed++;
  endtask

  task automatic test_empty();
    int vc, dc, dn, rc, ec, wn;
    run_deq(0, vc, dc, dn, rc, ec, wn);
    total++;
    if (ec !== 1 || wn !== 0 || vc !== -1 || dn !== 0 || rc !== 1)
      $display("FAIL empty: err %0d we %0d vld %0d dec %0d rdy %0d required 1 0 -1 0 1", ec, wn, vc, dn, rc);
    else passed++;
  endtask

  task automatic test_single();
    int vc, dc, dn, rc, ec, wn;
    foreach (img[i]) img[i] = ONES;
    img[0] = 5;
    load();
    sb.push_back(32'd5);
    run_deq(1, vc, dc, dn, rc, ec, wn);
    total++; if (dc !== exp_dc(1) || dn !== 1) $display("FAIL single_dec: cycle %0d n %0d required %0d 1", dc, dn, exp_dc(1)); else passed++;
    total++; if (rc !== exp_rc(1)) $display("FAIL single_ready: got %0d required %0d", rc, exp_rc(1)); else passed++;
    total++; if (mem[0] !== exp_tail(32'd5)) $display("FAIL single_mem0: got %h required %h", mem[0], exp_tail(32'd5)); else passed++;
  endtask

  task automatic test_full();
    int vc, dc, dn, rc, ec, wn, bad;
    for (int i = 0; i < DEPTH; i++) img[i] = KEY_W'(i);
    load();
    sb.push_back(32'd0);
    run_deq(DEPTH, vc, dc, dn, rc, ec, wn);
    total++; if (rc !== exp_rc(DEPTH)) $display("FAIL full_ready: got %0d required %0d", rc, exp_rc(DEPTH)); else passed++;
    total++; if (wn !== exp_wn(DEPTH)) $display("FAIL full_writes: got %0d required %0d", wn, exp_wn(DEPTH)); else passed++;
    bad = 0;
    for (int i = 0; i < DEPTH-1; i++) if (mem[i] !== KEY_W'(i+1)) bad++;
    total++; if (bad != 0) $display("FAIL full_shift: %0d slots wrong required 0", bad); else passed++;
    total++; if (mem[DEPTH-1] !== exp_tail(32'd15)) $display("FAIL full_tail: got %h required %h", mem[DEPTH-1], exp_tail(32'd15)); else passed++;
  endtask

  task automatic test_enq_busy();
    int vc, dc, dn, rc, ec, wn, bad;
    foreach (img[i]) img[i] = ONES;
    img[0] = 4; img[1] = 8;
    load();
    enq_busy = 1'b1; deq = 1'b1; count = CNT_W'(2); bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (deq_valid || bram_we || !deq_ready || deq_err || count_dec) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad != 0) $display("FAIL busy_block: %0d bad cycles required 0", bad); else passed++;
    enq_busy = 1'b0;
    sb.push_back(32'd4);
    run_deq(2, vc, dc, dn, rc, ec, wn);
    total++; if (vc !== 2 || rc !== exp_rc(2)) $display("FAIL busy_accept: vld %0d rdy %0d required 2 %0d", vc, rc, exp_rc(2)); else passed++;
    total++; if (mem[0] !== 32'd8) $display("FAIL busy_mem0: got %h required 8", mem[0]); else passed++;
  endtask

  task automatic test_rst_mid();
    int decs, swap_we;
    foreach (img[i]) img[i] = ONES;
    img[0] = 3; img[1] = 7; img[2] = 9; img[3] = 12;
    load();
    sb.push_back(32'd3);
    count = CNT_W'(4); deq = 1'b1; swap_we = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) swap_we = bram_we;
      if (k < 3) begin @(posedge clk); #1 deq = 1'b0; end
    end
    total++; if (swap_we !== 1) $display("FAIL rst_swap_we: got %0d required 1", swap_we); else passed++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bram_we !== 1'b0 || deq_ready !== 1'b1 || count_dec !== 1'b0 || deq_valid !== 1'b0 || deq_data !== '0)
      $display("FAIL rst_mid: we=%b rdy=%b dec=%b vld=%b data=%h required 0 1 0 0 0",
               bram_we, deq_ready, count_dec, deq_valid, deq_data);
    else passed++;
    decs = 0;
    repeat (12) begin @(negedge clk); if (count_dec || !deq_ready) decs++; end
    total++; if (decs != 0) $display("FAIL rst_no_dec: %0d bad cycles required 0", decs); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; deq = 1'b0; enq_busy = 1'b0; count = '0;
    foreach (img[i]) img[i] = ONES;
    test_reset();
    test_basic();
    test_empty();
    test_single();
    test_full();
    test_enq_busy();
    test_rst_mid();
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d keys never returned required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
